// File: rtl/axi_frame_tx.sv
// Frames a non-stallable sample stream into AXI-Stream packets with tlast.
// Frames are dropped on almost_full at start, or truncated when the skid fills up.
module axi_frame_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 256,
  parameter int SKID_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  async_reset,
  input  logic                  enable,
  input  logic                  clear_stats,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  almost_full,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic [CNT_WIDTH-1:0]  trunc_cnt
);

  localparam int FW = $clog2(FRAME_LEN);
  localparam int PW = $clog2(SKID_DEPTH);
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [FW-1:0] LAST = FW'(FRAME_LEN - 1);
  localparam logic [PW:0] RSV = (PW+1)'(SKID_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DROP
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [FW-1:0]   in_cnt;
  logic [EW-1:0]   mem [SKID_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     fcnt;
  logic [PW:0]     occ;
  logic            start;
  logic            wr;
  logic            wr_last;
  logic            wr_user;
  logic            drop_inc;
  logic            trunc_inc;
  logic [EW-1:0]   wr_ent;
  logic            pop;
  logic            load;
  logic            fifo_pop;
  logic            fifo_push;

  // Occupancy counts the output register plus the entries queued behind it.
  assign occ    = fcnt + (PW+1)'(m_axis_tvalid);
  assign start  = in_valid && (in_cnt == '0);
  assign wr_ent = {wr_user, wr_last, in_data};

  always_comb begin
    state_nx  = state;
    wr        = 1'b0;
    wr_last   = 1'b0;
    wr_user   = 1'b0;
    drop_inc  = 1'b0;
    trunc_inc = 1'b0;
    if (in_valid) begin
      if (start) begin
        if (!enable) begin
          state_nx = IDLE;
        end else if (almost_full) begin
          state_nx = DROP;
          drop_inc = 1'b1;
        end else begin
          wr       = 1'b1;
          state_nx = PASS;
        end
      end else if (state == PASS) begin
        wr = 1'b1;
        if (in_cnt == LAST) begin
          wr_last  = 1'b1;
          state_nx = IDLE;
        end
      end
      // Last free slot is kept back so a truncating write always fits.
      if (wr && occ >= RSV) begin
        wr_last   = 1'b1;
        wr_user   = 1'b1;
        trunc_inc = 1'b1;
        state_nx  = DROP;
      end
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state     <= IDLE;
      in_cnt    <= '0;
      drop_cnt  <= '0;
      trunc_cnt <= '0;
    end else begin
      state <= state_nx;
      if (in_valid) begin
        in_cnt <= (in_cnt == LAST) ? '0 : in_cnt + FW'(1);
      end
      if (clear_stats) begin
        drop_cnt  <= '0;
        trunc_cnt <= '0;
      end else begin
        if (drop_inc && drop_cnt != CMAX) begin
          drop_cnt <= drop_cnt + CNT_WIDTH'(1);
        end
        if (trunc_inc && trunc_cnt != CMAX) begin
          trunc_cnt <= trunc_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign pop       = m_axis_tvalid && m_axis_tready;
  assign load      = !m_axis_tvalid || pop;
  assign fifo_pop  = load && (fcnt != '0);
  assign fifo_push = wr && !(load && fcnt == '0);

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem[wr_ptr] <= wr_ent;
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fcnt          <= '0;
    end else begin
      if (load) begin
        if (fcnt != '0) begin
          {m_axis_tuser, m_axis_tlast, m_axis_tdata} <= mem[rd_ptr];
          m_axis_tvalid <= 1'b1;
        end else if (wr) begin
          {m_axis_tuser, m_axis_tlast, m_axis_tdata} <= wr_ent;
          m_axis_tvalid <= 1'b1;
        end else begin
          m_axis_tvalid <= 1'b0;
        end
      end
      if (fifo_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fcnt <= fcnt + (PW+1)'(1);
        2'b01:   fcnt <= fcnt - (PW+1)'(1);
        default: fcnt <= fcnt;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_frame_tx.sv
// Scoreboard bench for axi_frame_tx: frame-level reference model feeds an
// expected-beat queue that an independent AXI monitor drains and checks.
module tb_axi_frame_tx;

  localparam int DW = 16;
  localparam int FL = 8;
  localparam int SD = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          async_reset = 1'b0;
  logic          enable = 1'b0;
  logic          clear_stats = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          almost_full = 1'b0;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          m_axis_tready = 1'b0;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] trunc_cnt;

  axi_frame_tx #(
    .DATA_WIDTH(DW),
    .FRAME_LEN (FL),
    .SKID_DEPTH(SD),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .async_reset  (async_reset),
    .enable       (enable),
    .clear_stats  (clear_stats),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .almost_full  (almost_full),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tready(m_axis_tready),
    .drop_cnt     (drop_cnt),
    .trunc_cnt    (trunc_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  logic [DW+1:0] exp_q[$];
  int pushed = 0;
  int popped = 0;
  int last_push = 0;
  int pos = 0;
  int mode = 0;
  int drops = 0;
  int truncs = 0;
  logic [DW-1:0] next_d = '0;

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(int v);
    return (v > (2**CW - 1)) ? (2**CW - 1) : v;
  endfunction

  // mode: 0 no frame, 1 frame passing, 2 frame discarded
  task automatic model(logic [DW-1:0] d);
    int occ;
    bit w;
    occ = pushed - popped;
    w = 1'b0;
    if (pos == 0) begin
      if (!enable) mode = 0;
      else if (almost_full) begin
        mode = 2;
        drops++;
      end else w = 1'b1;
    end else if (mode == 1) begin
      w = 1'b1;
    end
    if (w) begin
      if (occ >= SD - 1) begin
        exp_q.push_back({2'b11, d});
        truncs++;
        mode = 2;
      end else if (pos == FL - 1) begin
        exp_q.push_back({2'b01, d});
        mode = 0;
      end else begin
        exp_q.push_back({2'b00, d});
        mode = 1;
      end
      pushed++;
      last_push = 1;
    end
    pos = (pos + 1) % FL;
  endtask

  task automatic cyc(bit iv, bit en, bit af, bit rdy, bit clr);
    @(posedge clk);
    #1;
    check("drop_cnt", drop_cnt, sat(drops));
    check("trunc_cnt", trunc_cnt, sat(truncs));
    last_push = 0;
    enable = en;
    almost_full = af;
    m_axis_tready = rdy;
    clear_stats = clr;
    in_valid = iv;
    if (iv) begin
      in_data = next_d;
      model(next_d);
      next_d = next_d + 1'b1;
    end
    if (clr) begin
      drops = 0;
      truncs = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    async_reset = 1'b1;
    in_valid = 1'b0;
    clear_stats = 1'b0;
    exp_q.delete();
    pushed = 0;
    last_push = 0;
    pos = 0;
    mode = 0;
    drops = 0;
    truncs = 0;
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tuser", m_axis_tuser, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_trunc", trunc_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    async_reset = 1'b0;
  endtask

  logic          pv = 1'b0;
  logic          pr = 1'b0;
  logic [DW+1:0] pe = '0;
  logic [DW+1:0] cur;
  logic [DW+1:0] ebeat;

  always @(negedge clk) begin
    if (async_reset) begin
      pv = 1'b0;
      popped = 0;
    end else begin
      cur = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (pv && !pr) begin
        check("axi_hold", {m_axis_tvalid, cur}, {1'b1, pe});
      end
      check("tvalid", m_axis_tvalid, longint'((pushed - last_push) != popped));
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL beat: got %0h expected no beat", cur);
        end else begin
          ebeat = exp_q.pop_front();
          if (cur != ebeat) begin
            fails++;
            $display("FAIL beat: got %0h expected %0h", cur, ebeat);
          end
        end
        popped++;
      end
      pv = m_axis_tvalid;
      pr = m_axis_tready;
      pe = cur;
    end
  end

  initial begin
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, 1, 0);
    repeat (4) cyc(0, 1, 0, 1, 0);
    for (int i = 0; i < 16; i++) cyc(1, 1, i < 8, 1, 0);
    repeat (4) cyc(0, 1, 0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 0);
    repeat (6) cyc(0, 1, 0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 1, 0);
    repeat (4) cyc(0, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1, 0);
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, 1, 0);
    repeat (4) cyc(0, 1, 0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) cyc(1, i < 2, 0, 1, 0);
    repeat (4) cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 0, 1, 1);
    for (int i = 0; i < 40; i++) cyc(1, 1, 1, 1, 0);
    cyc(1, 1, 1, 1, 1);
    for (int i = 0; i < 7; i++) cyc(1, 1, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) != 0,
          $urandom_range(0, 9) != 0,
          $urandom_range(0, 4) == 0,
          ((i / 50) % 2 == 1) ? ($urandom_range(0, 3) == 0)
                              : ($urandom_range(0, 3) != 0),
          $urandom_range(0, 49) == 0);
    end
    repeat (20) cyc(0, 1, 0, 1, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
